vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for VGA/DVI style displays. A free-running clock
// divider produces a one-clk-wide pixel clock-enable; on every pixel tick the
// horizontal/vertical raster counters advance. The counters are decoded into
// sync and data-enable, which then pass through a short delay line so they
// can be kept aligned with downstream pixel-generation pipeline stages.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   run enable; low freezes raster and delay line
//   restart      in   synchronous restart of raster to (0,0), beats en
//   pix_ce       out  pixel clock-enable (divider terminal count)
//   hsync        out  horizontal sync, delayed, active level HSYNC_POL
//   vsync        out  vertical sync, delayed, active level VSYNC_POL
//   de           out  data enable (active picture area), delayed
//   x            out  current horizontal count, undelayed
//   y            out  current vertical count, undelayed
//   line_start   out  pixel tick with h==0
//   frame_start  out  pixel tick with h==0 and v==0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int HSYNC_POL  = 0,
   parameter int VSYNC_POL  = 0,
   parameter int CLK_DIV    = 4,
   parameter int PIPE_DELAY = 0,
   parameter int COORD_W    = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               restart,
   output logic               pix_ce,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_DISPLAY + H_FRONT;
   localparam int HS_STOP  = HS_START + H_SYNC;
   localparam int VS_START = V_DISPLAY + V_FRONT;
   localparam int VS_STOP  = VS_START + V_SYNC;

   // A one-bit divider is kept for CLK_DIV=1; it simply stays at zero.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

   // Output level when the corresponding sync is inactive.
   localparam logic HS_IDLE = (HSYNC_POL == 0) ? 1'b1 : 1'b0;
   localparam logic VS_IDLE = (VSYNC_POL == 0) ? 1'b1 : 1'b0;

   // Delay-line bit positions within a stage.
   localparam int B_HS = 2;
   localparam int B_VS = 1;
   localparam int B_DE = 0;

   logic [DIV_W-1:0]   div_cnt;
   logic [COORD_W-1:0] h;
   logic [COORD_W-1:0] v;
   logic               tick;
   logic               hs_raw;
   logic               vs_raw;
   logic               de_raw;
   logic [2:0]         dly [0:PIPE_DELAY];

   // ------------------------------------------------------------------------
   // Clock divider: free-runs independent of en, cleared by restart.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (restart || (div_cnt == DIV_LAST)) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign pix_ce = (div_cnt == DIV_LAST);

   // rst_n is folded in so the strobes read low while reset is held, which
   // matters when CLK_DIV=1 and pix_ce is permanently high.
   assign tick = pix_ce && en && !restart && rst_n;

   // ------------------------------------------------------------------------
   // Raster counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h <= '0;
         v <= '0;
      end else if (restart) begin
         h <= '0;
         v <= '0;
      end else if (tick) begin
         if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
               v <= '0;
            end else begin
               v <= v + 1'b1;
            end
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Decode of the current raster position (compared in 32-bit so a sync
   // region ending exactly at the line/frame end cannot overflow COORD_W).
   // ------------------------------------------------------------------------
   always_comb begin
      hs_raw = (int'(h) >= HS_START) && (int'(h) < HS_STOP);
      vs_raw = (int'(v) >= VS_START) && (int'(v) < VS_STOP);
      de_raw = (int'(h) < H_DISPLAY) && (int'(v) < V_DISPLAY);
   end

   // ------------------------------------------------------------------------
   // Delay line: PIPE_DELAY+1 stages, advancing on pixel ticks only. Stages
   // hold active-high flags; polarity is applied at the output.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= PIPE_DELAY; i++) begin
            dly[i] <= 3'b000;
         end
      end else if (restart) begin
         for (int i = 0; i <= PIPE_DELAY; i++) begin
            dly[i] <= 3'b000;
         end
      end else if (tick) begin
         dly[0] <= {hs_raw, vs_raw, de_raw};
         for (int i = 1; i <= PIPE_DELAY; i++) begin
            dly[i] <= dly[i-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign hsync       = dly[PIPE_DELAY][B_HS] ^ HS_IDLE;
   assign vsync       = dly[PIPE_DELAY][B_VS] ^ VS_IDLE;
   assign de          = dly[PIPE_DELAY][B_DE];
   assign x           = h;
   assign y           = v;
   assign line_start  = tick && (h == '0);
   assign frame_start = tick && (h == '0) && (v == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Four instances of vga_timing_gen with different parameter sets:
//   0: all defaults (CLK_DIV=4, PIPE_DELAY=0)
//   1: default raster, PIPE_DELAY=3, HSYNC_POL=1, CLK_DIV=1
//   2: tiny raster H 8/2/2/2, V 4/1/1/1, CLK_DIV=1 (98-clk frame)
//   3: tiny horizontal 8/2/2/2, default vertical, CLK_DIV=1
// Each instance has its own rst_n/en/restart so tests can run one at a time.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0]      rst_n_v;
  logic [ND-1:0]      en_v;
  logic [ND-1:0]      restart_v;
  logic [ND-1:0]      pix_ce_w;
  logic [ND-1:0]      hsync_w;
  logic [ND-1:0]      vsync_w;
  logic [ND-1:0]      de_w;
  logic [ND-1:0]      ls_w;
  logic [ND-1:0]      fs_w;
  logic [ND-1:0][9:0] x_w;
  logic [ND-1:0][9:0] y_w;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n_v[0]), .en(en_v[0]), .restart(restart_v[0]),
    .pix_ce(pix_ce_w[0]), .hsync(hsync_w[0]), .vsync(vsync_w[0]), .de(de_w[0]),
    .x(x_w[0]), .y(y_w[0]), .line_start(ls_w[0]), .frame_start(fs_w[0])
  );

  vga_timing_gen #(.PIPE_DELAY(3), .HSYNC_POL(1), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n_v[1]), .en(en_v[1]), .restart(restart_v[1]),
    .pix_ce(pix_ce_w[1]), .hsync(hsync_w[1]), .vsync(vsync_w[1]), .de(de_w[1]),
    .x(x_w[1]), .y(y_w[1]), .line_start(ls_w[1]), .frame_start(fs_w[1])
  );

  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .CLK_DIV(1)) dut_c (
    .clk(clk), .rst_n(rst_n_v[2]), .en(en_v[2]), .restart(restart_v[2]),
    .pix_ce(pix_ce_w[2]), .hsync(hsync_w[2]), .vsync(vsync_w[2]), .de(de_w[2]),
    .x(x_w[2]), .y(y_w[2]), .line_start(ls_w[2]), .frame_start(fs_w[2])
  );

  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .CLK_DIV(1)) dut_d (
    .clk(clk), .rst_n(rst_n_v[3]), .en(en_v[3]), .restart(restart_v[3]),
    .pix_ce(pix_ce_w[3]), .hsync(hsync_w[3]), .vsync(vsync_w[3]), .de(de_w[3]),
    .x(x_w[3]), .y(y_w[3]), .line_start(ls_w[3]), .frame_start(fs_w[3])
  );

  // ---------------- scoreboard and bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    int   d;
    int   px;
    int   py;
    logic hs;
    logic vs;
    logic de;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int d, input int px, input int py,
                         input logic hs, input logic vs, input logic de);
    vec_t v;
    v.d = d; v.px = px; v.py = py; v.hs = hs; v.vs = vs; v.de = de;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int d);
    rst_n_v[d]   = 1'b0;
    en_v[d]      = 1'b1;
    restart_v[d] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_v[d]   = 1'b1;
  endtask

  task automatic wait_pos(input int d, input int px, input int py,
                          input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (int'(x_w[d]) == px && int'(y_w[d]) == py) ok = 1'b1;
    end
  endtask

  function automatic logic strobe(input int d, input bit frame);
    return frame ? fs_w[d] : ls_w[d];
  endfunction

  // Finds the next strobe, then counts clks (and per-clk output levels)
  // up to the strobe after it.
  task automatic measure(input int d, input bit frame, input int budget,
                         output int period, output int de_n, output int hs_lo,
                         output int vs_lo, output int pce_n, output bit ok);
    period = 0; de_n = 0; hs_lo = 0; vs_lo = 0; pce_n = 0;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (strobe(d, frame)) ok = 1'b1;
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
        de_n  += int'(de_w[d]);
        hs_lo += int'(!hsync_w[d]);
        vs_lo += int'(!vsync_w[d]);
        pce_n += int'(pix_ce_w[d]);
        @(negedge clk);
        period++;
        if (strobe(d, frame)) ok = 1'b1;
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  bit   ok;
  int   period, de_n, hs_lo, vs_lo, pce_n;
  int   hold_bad, strobe_seen, pce_cnt;
  logic [2:0] exp_v;
  logic exp_bit;
  logic [0:6] pce_seq;
  logic [0:6] fs_seq;

  initial begin
    rst_n_v   = '0;
    en_v      = '1;
    restart_v = '0;

    // Reset state
    @(negedge clk);
    check("rst_x",      x_w[0], 0);
    check("rst_y",      y_w[0], 0);
    check("rst_hsync",  hsync_w[0], 1);
    check("rst_vsync",  vsync_w[0], 1);
    check("rst_de",     de_w[0], 0);
    check("rst_pix_ce", pix_ce_w[0], 0);
    check("rst_ls",     ls_w[0], 0);
    check("rst_fs",     fs_w[0], 0);
    check("rst_hsync_pol1", hsync_w[1], 0);
    check("rst_pix_ce_div1", pix_ce_w[2], 1);
    check("rst_fs_div1",     fs_w[2], 0);

    // Position-keyed vectors: {instance, x, y, hsync, vsync, de}
    add_vec(0,   0, 0, 1, 1, 0);
    add_vec(0,   1, 0, 1, 1, 1);
    add_vec(0, 640, 0, 1, 1, 1);
    add_vec(0, 641, 0, 1, 1, 0);
    add_vec(0, 656, 0, 1, 1, 0);
    add_vec(0, 657, 0, 0, 1, 0);
    add_vec(0, 752, 0, 0, 1, 0);
    add_vec(0, 753, 0, 1, 1, 0);
    add_vec(0,   0, 1, 1, 1, 0);
    add_vec(0,   1, 1, 1, 1, 1);
    add_vec(1,   3, 0, 0, 1, 0);
    add_vec(1,   4, 0, 0, 1, 1);
    add_vec(1, 643, 0, 0, 1, 1);
    add_vec(1, 644, 0, 0, 1, 0);
    add_vec(1, 659, 0, 0, 1, 0);
    add_vec(1, 660, 0, 1, 1, 0);
    add_vec(1, 755, 0, 1, 1, 0);
    add_vec(1, 756, 0, 0, 1, 0);
    add_vec(3,   1, 479, 1, 1, 1);
    add_vec(3,   1, 480, 1, 1, 0);
    add_vec(3,   0, 490, 1, 1, 0);
    add_vec(3,   1, 490, 1, 0, 0);
    add_vec(3,   0, 492, 1, 0, 0);
    add_vec(3,   1, 492, 1, 1, 0);
    add_vec(3,  11, 492, 0, 1, 0);
    add_vec(3,  13, 492, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].d != vecs[i-1].d) do_reset(vecs[i].d);
      exp_q.push_back({vecs[i].hs, vecs[i].vs, vecs[i].de});
      wait_pos(vecs[i].d, vecs[i].px, vecs[i].py, 20000, ok);
      check($sformatf("reach d%0d x%0d y%0d", vecs[i].d, vecs[i].px, vecs[i].py), ok, 1);
      exp_v = exp_q.pop_front();
      check($sformatf("hs_vs_de d%0d x%0d y%0d", vecs[i].d, vecs[i].px, vecs[i].py),
            {hsync_w[vecs[i].d], vsync_w[vecs[i].d], de_w[vecs[i].d]}, exp_v);
    end

    // Divider phase after reset release on the default instance
    pce_seq = 7'b0010001;
    fs_seq  = 7'b0010000;
    do_reset(0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("pix_ce_edge%0d", k + 1), pix_ce_w[0], pce_seq[k]);
      check($sformatf("fs_edge%0d", k + 1), fs_w[0], fs_seq[k]);
      check($sformatf("ls_edge%0d", k + 1), ls_w[0], fs_seq[k]);
    end

    // Line period and per-line content
    measure(0, 1'b0, 4000, period, de_n, hs_lo, vs_lo, pce_n, ok);
    check("line_found", ok, 1);
    check("line_period_clk", period, 3200);
    check("line_de_clk", de_n, 2560);
    check("line_hsync_low_clk", hs_lo, 384);
    check("line_pix_ce_count", pce_n, 800);

    // en held low at x=300
    do_reset(0);
    wait_pos(0, 300, 0, 2000, ok);
    check("reach_x300", ok, 1);
    en_v[0] = 1'b0;
    hold_bad = 0; strobe_seen = 0; pce_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (x_w[0] != 10'd300 || y_w[0] != 10'd0) hold_bad++;
      if (de_w[0] != 1'b1 || hsync_w[0] != 1'b1 || vsync_w[0] != 1'b1) hold_bad++;
      if (ls_w[0] || fs_w[0]) strobe_seen++;
      pce_cnt += int'(pix_ce_w[0]);
    end
    check("en_hold_state", hold_bad, 0);
    check("en_hold_strobes", strobe_seen, 0);
    check("en_hold_pix_ce", pce_cnt, 25);
    en_v[0] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      if (x_w[0] != 10'd300) ok = 1'b1;
    end
    check("en_resume_seen", ok, 1);
    check("en_resume_x", x_w[0], 301);
    check("en_resume_y", y_w[0], 0);

    // restart from inside the hsync pulse
    wait_pos(0, 700, 1, 8000, ok);
    check("reach_x700_y1", ok, 1);
    check("pre_restart_hsync", hsync_w[0], 0);
    restart_v[0] = 1'b1;
    @(negedge clk);
    check("restart_x", x_w[0], 0);
    check("restart_y", y_w[0], 0);
    check("restart_hsync", hsync_w[0], 1);
    check("restart_vsync", vsync_w[0], 1);
    check("restart_de", de_w[0], 0);
    check("restart_fs", fs_w[0], 0);
    restart_v[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      exp_bit = (k == 3);
      check($sformatf("post_restart_fs%0d", k), fs_w[0], exp_bit);
    end

    // CLK_DIV=1, tiny raster
    do_reset(2);
    #1;
    check("div1_first_fs", fs_w[2], 1);
    check("div1_first_ls", ls_w[2], 1);
    measure(2, 1'b1, 300, period, de_n, hs_lo, vs_lo, pce_n, ok);
    check("div1_frame_found", ok, 1);
    check("div1_frame_period", period, 98);
    check("div1_pix_ce_const", pce_n, 98);
    check("div1_frame_de", de_n, 32);
    check("div1_frame_hs_low", hs_lo, 14);
    check("div1_frame_vs_low", vs_lo, 14);
    repeat (38) @(negedge clk);
    check("div1_mid_x", x_w[2], 10);
    check("div1_mid_y", y_w[2], 2);
    @(posedge clk);
    #1;
    check("div1_pre_rst_x", x_w[2], 11);
    check("div1_pre_rst_hsync", hsync_w[2], 0);
    #1 rst_n_v[2] = 1'b0;
    #1;
    check("async_rst_x", x_w[2], 0);
    check("async_rst_y", y_w[2], 0);
    check("async_rst_hsync", hsync_w[2], 1);
    check("async_rst_vsync", vsync_w[2], 1);
    check("async_rst_de", de_w[2], 0);
    check("async_rst_fs", fs_w[2], 0);
    check("async_rst_ls", ls_w[2], 0);
    check("async_rst_pix_ce", pix_ce_w[2], 1);
    @(negedge clk);
    rst_n_v[2]   = 1'b1;
    restart_v[2] = 1'b1;
    #1;
    check("restart_blocks_fs", fs_w[2], 0);
    check("restart_blocks_ls", ls_w[2], 0);
    @(negedge clk);
    check("restart_hold_x", x_w[2], 0);
    check("restart_hold_fs", fs_w[2], 0);
    restart_v[2] = 1'b0;
    #1;
    check("after_restart_fs", fs_w[2], 1);

    // Full frame with default vertical timing
    do_reset(3);
    measure(3, 1'b1, 8000, period, de_n, hs_lo, vs_lo, pce_n, ok);
    check("vframe_found", ok, 1);
    check("vframe_period", period, 7350);
    check("vframe_de", de_n, 3840);
    check("vframe_vs_low", vs_lo, 28);
    check("vframe_hs_low", hs_lo, 1050);
    check("vframe_pix_ce", pce_n, 7350);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
